// File: rtl/chip8_mem_arb_if.sv
// Client bus for the shared CHIP-8 RAM. The ports are flat vectors; port p
// uses addr[p*ADDR_W +: ADDR_W] and wdata[p*DATA_W +: DATA_W].
interface chip8_mem_arb_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        ack;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;

  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/chip8_mem_arb.sv
// Shared CHIP-8 RAM with round-robin arbitration and a post-reset clear sweep.
// Optional macro CHIP8_MEM_FONT_PRELOAD_EN makes the sweep load the hex font at FONT_BASE.
module chip8_mem_arb #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4096,
  parameter int FONT_BASE = 'h050
) (
  input  logic             clk,
  input  logic             rst,
  chip8_mem_arb_if.slave   bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int MW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    clr_addr;
  logic [DATA_W-1:0]    clr_data;
  logic [PW-1:0]        rr_ptr, gnt_idx;
  logic                 gnt_vld;
  logic [NUM_PORTS-1:0] elig, ack;
  logic [ADDR_W-1:0]    gnt_addr;
  logic [DATA_W-1:0]    gnt_wdata, mem_q, rdata;
  logic                 gnt_we, gnt_in_range;
  logic [DATA_W-1:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_addr == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  // The ack register doubles as the mask: a port is never granted in its own ack cycle.
  always_comb begin
    int p;
    elig    = bus.req & ~ack;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    p       = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p = int'(rr_ptr) + i;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!gnt_vld && elig[p] && state == RUN) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(p);
      end
    end
  end

  always_comb begin
    gnt_addr     = bus.addr[gnt_idx*ADDR_W +: ADDR_W];
    gnt_wdata    = bus.wdata[gnt_idx*DATA_W +: DATA_W];
    gnt_we       = bus.we[gnt_idx];
    gnt_in_range = int'(gnt_addr) < DEPTH;
    mem_q        = gnt_in_range ? mem[gnt_addr[MW-1:0]] : '0;
  end

`ifdef CHIP8_MEM_FONT_PRELOAD_EN
  localparam logic [639:0] FONT = {
    64'hF0909090F0206020, 64'h2070F010F080F0F0, 64'h10F010F09090F010,
    64'h10F080F010F0F080, 64'hF090F0F010204040, 64'hF090F090F0F090F0,
    64'h10F0F090F09090E0, 64'h90E090E0F0808080, 64'hF0E0909090E0F080,
    64'hF080F0F080F08080};
  always_comb begin
    clr_data = '0;
    if (int'(clr_addr) >= FONT_BASE && int'(clr_addr) < FONT_BASE + 80)
      clr_data = DATA_W'(FONT[639 - 8*(int'(clr_addr) - FONT_BASE) -: 8]);
  end
`else
  assign clr_data = '0;
`endif

  // A write granted in a reset cycle is dropped along with its ack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_addr[MW-1:0]] <= clr_data;
      else if (gnt_vld && gnt_we && gnt_in_range)
        mem[gnt_addr[MW-1:0]] <= gnt_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack      <= '0;
      rdata    <= '0;
      clr_addr <= '0;
      rr_ptr   <= '0;
    end else begin
      ack <= '0;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (gnt_vld) begin
        ack    <= NUM_PORTS'(1) << gnt_idx;
        rdata  <= mem_q;
        rr_ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign bus.ack   = ack;
  assign bus.rdata = rdata;
  assign bus.busy  = (state == CLEAR);
endmodule

// File: tb/tb_chip8_mem_arb.sv
// Bench for chip8_mem_arb: vector table, hand-written corner sequences and a
// randomized multi-port run against a behavioural model.
module tb_chip8_mem_arb;
  localparam int NP = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  chip8_mem_arb_if #(.NUM_PORTS(NP), .ADDR_W(12), .DATA_W(8)) u_if ();
  chip8_mem_arb_if #(.NUM_PORTS(NP), .ADDR_W(12), .DATA_W(8)) d_if ();

  chip8_mem_arb #(.NUM_PORTS(NP), .ADDR_W(12), .DATA_W(8), .DEPTH(4096), .FONT_BASE('h050))
    u_dut (.clk(clk), .rst(rst), .bus(u_if));
  chip8_mem_arb #(.NUM_PORTS(NP), .ADDR_W(12), .DATA_W(8), .DEPTH(3000), .FONT_BASE('h050))
    d_dut (.clk(clk), .rst(rst), .bus(d_if));

  typedef struct {
    int         p;
    logic       w;
    logic [11:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(int p, logic w, logic [11:0] a, logic [7:0] d, logic [7:0] e);
    vec_t v;
    v.p = p; v.w = w; v.a = a; v.d = d; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] font_exp(input logic [7:0] f);
`ifdef CHIP8_MEM_FONT_PRELOAD_EN
    return f;
`else
    return 8'h00 & f;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge one idle cycle after the ack.
  task automatic access(input int dut, input int p, input logic w, input logic [11:0] a,
                        input logic [7:0] d, output logic [7:0] rd, output int lat);
    lat = 0;
    rd  = '0;
    if (dut == 0) begin
      u_if.req[p] = 1'b1; u_if.we[p] = w; u_if.addr[p*12 +: 12] = a; u_if.wdata[p*8 +: 8] = d;
    end else begin
      d_if.req[p] = 1'b1; d_if.we[p] = w; d_if.addr[p*12 +: 12] = a; d_if.wdata[p*8 +: 8] = d;
    end
    do begin
      @(negedge clk);
      lat++;
    end while (!((dut == 0) ? u_if.ack[p] : d_if.ack[p]) && lat < 20);
    rd = (dut == 0) ? u_if.rdata : d_if.rdata;
    if (dut == 0) u_if.req[p] = 1'b0;
    else          d_if.req[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.req = '0;
    d_if.req = '0;
    @(negedge clk);
    check("rst_ack", u_if.ack, 0);
    check("rst_rdata", u_if.rdata, 0);
    check("rst_busy", u_if.busy, 1);
    rst = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    int n = 0;
    while (u_if.busy && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 4096);
  endtask

  logic [7:0] rd;
  int         lat;

  initial begin
    logic [NP-1:0] exp3 [4];
    logic [7:0]    mm [4096];
    logic [NP-1:0] exp_ack, nack, elig;
    logic [7:0]    exp_rd;
    logic          pend [NP];
    logic          cwe  [NP];
    logic [11:0]   caddr [NP];
    logic [7:0]    cdat [NP];
    int            rr, g;

    u_if.req = '0; u_if.we = '0; u_if.addr = '0; u_if.wdata = '0;
    d_if.req = '0; d_if.we = '0; d_if.addr = '0; d_if.wdata = '0;
    @(negedge clk);

    do_reset();
    check("d_rst_busy", d_if.busy, 1);
    wait_clear("clear_cycles");
    check("d_busy_done", d_if.busy, 0);

    // All three ports request together from rr_ptr=0; port 0 keeps requesting.
    exp3[0] = 3'b001; exp3[1] = 3'b010; exp3[2] = 3'b100; exp3[3] = 3'b001;
    for (int p = 0; p < NP; p++) u_if.addr[p*12 +: 12] = 12'h010 + 12'(p);
    u_if.we  = '0;
    u_if.req = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_ack%0d", k), u_if.ack, exp3[k]);
      check($sformatf("rr_rdata%0d", k), u_if.rdata, 0);
      if (k == 1) u_if.req[1] = 1'b0;
      if (k == 2) u_if.req[2] = 1'b0;
      if (k == 3) u_if.req[0] = 1'b0;
    end
    @(negedge clk);
    check("rr_idle_ack", u_if.ack, 0);

    vt.push_back(mkv(0, 0, 12'h000, 8'h00, 8'h00));
    vt.push_back(mkv(1, 0, 12'h200, 8'h00, 8'h00));
    vt.push_back(mkv(2, 0, 12'hFFF, 8'h00, 8'h00));
    vt.push_back(mkv(0, 0, 12'h050, 8'h00, font_exp(8'hF0)));
    vt.push_back(mkv(1, 0, 12'h051, 8'h00, font_exp(8'h90)));
    vt.push_back(mkv(1, 0, 12'h09F, 8'h00, font_exp(8'h80)));
    vt.push_back(mkv(2, 0, 12'h0A0, 8'h00, 8'h00));
    vt.push_back(mkv(0, 1, 12'h200, 8'hA5, 8'h00));
    vt.push_back(mkv(0, 0, 12'h200, 8'h00, 8'hA5));
    vt.push_back(mkv(2, 1, 12'hFFF, 8'h3C, 8'h00));
    vt.push_back(mkv(1, 0, 12'hFFF, 8'h00, 8'h3C));
    vt.push_back(mkv(1, 1, 12'h200, 8'h11, 8'hA5));
    vt.push_back(mkv(2, 0, 12'h200, 8'h00, 8'h11));
    vt.push_back(mkv(0, 1, 12'h054, 8'hEE, font_exp(8'hF0)));
    vt.push_back(mkv(1, 0, 12'h054, 8'h00, 8'hEE));
    foreach (vt[i]) begin
      access(0, vt[i].p, vt[i].w, vt[i].a, vt[i].d, rd, lat);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 1);
    end

    // DEPTH=3000 instance: out-of-range write must not alias onto 0x400.
    access(1, 1, 1'b1, 12'h400, 8'h33, rd, lat);
    check("oor_w400_rdata", rd, 8'h00);
    access(1, 1, 1'b1, 12'hC00, 8'h77, rd, lat);
    check("oor_wC00_rdata", rd, 8'h00);
    check("oor_wC00_lat", lat, 1);
    access(1, 1, 1'b0, 12'hC00, 8'h00, rd, lat);
    check("oor_rC00_rdata", rd, 8'h00);
    check("oor_rC00_lat", lat, 1);
    access(1, 0, 1'b0, 12'h400, 8'h00, rd, lat);
    check("oor_r400_rdata", rd, 8'h33);

    // Write granted in the same cycle as rst: dropped, and the clear reruns.
    u_if.req[0] = 1'b1; u_if.we[0] = 1'b1; u_if.addr[11:0] = 12'h123; u_if.wdata[7:0] = 8'h5A;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", u_if.ack, 0);
    check("midrst_busy", u_if.busy, 1);
    rst = 1'b0;
    u_if.req = '0;
    wait_clear("midrst_clear_cycles");
    access(0, 0, 1'b0, 12'h123, 8'h00, rd, lat);
    check("midrst_r123", rd, 8'h00);
    access(0, 1, 1'b0, 12'h200, 8'h00, rd, lat);
    check("midrst_r200", rd, 8'h00);

    // Randomized traffic from all ports against the behavioural model.
    do_reset();
    wait_clear("rnd_clear_cycles");
    foreach (mm[i]) mm[i] = 8'h00;
    rr = 0; exp_ack = '0; exp_rd = '0;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 1'b0; cwe[p] = 1'b0; caddr[p] = '0; cdat[p] = '0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_ack", u_if.ack, exp_ack);
      if (exp_ack != 0) check("rnd_rdata", u_if.rdata, exp_rd);
      for (int p = 0; p < NP; p++) begin
        if (exp_ack[p]) pend[p] = 1'b0;
        else if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]  = 1'b1;
          cwe[p]   = 1'($urandom_range(0, 1));
          caddr[p] = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'h300 + 12'($urandom_range(0, 15));
          cdat[p]  = 8'($urandom);
        end
        u_if.req[p] = pend[p];
        u_if.we[p]  = cwe[p];
        u_if.addr[p*12 +: 12] = caddr[p];
        u_if.wdata[p*8 +: 8]  = cdat[p];
      end
      elig = u_if.req & ~exp_ack;
      g = -1;
      for (int i = 0; i < NP; i++)
        if (g < 0 && elig[(rr + i) % NP]) g = (rr + i) % NP;
      nack = '0;
      if (g >= 0) begin
        nack[g] = 1'b1;
        exp_rd  = mm[caddr[g]];
        if (cwe[g]) mm[caddr[g]] = cdat[g];
        rr = (g + 1) % NP;
      end
      exp_ack = nack;
      @(negedge clk);
    end
    u_if.req = '0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
